// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg
// Shared types and constants for the reorder buffer slice: tag/data/register
// types, the invalid tag, entry-type encodings and tag <-> index helpers.
// Tags are 1-based: entry index i carries tag i+1, tag 0 means "no producer".
package reorder_buffer_pkg;

  localparam int ROB_SIZE  = 16;
  localparam int ROB_ID_W  = 5;
  localparam int ROB_IDX_W = 4;

  typedef logic [ROB_ID_W-1:0]  rob_id_t;
  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [31:0]          data_t;
  typedef logic [4:0]           reg_pos_t;

  localparam rob_id_t  INVALID_ROB = '0;
  localparam reg_pos_t ZERO_REG    = '0;

  typedef enum logic [1:0] {
    ROB_TYPE_REG    = 2'd0,
    ROB_TYPE_STORE  = 2'd1,
    ROB_TYPE_BRANCH = 2'd2
  } rob_type_t;

  function automatic rob_idx_t tag_to_idx(rob_id_t id);
    rob_id_t t;
    t = id - rob_id_t'(1);
    return t[ROB_IDX_W-1:0];
  endfunction

  // Tags above ROB_SIZE would alias onto low entries after truncation.
  function automatic logic tag_in_range(rob_id_t id);
    return (id != INVALID_ROB) && (id <= rob_id_t'(ROB_SIZE));
  endfunction

  function automatic rob_id_t idx_to_tag(rob_idx_t idx);
    return rob_id_t'({1'b0, idx}) + rob_id_t'(1);
  endfunction

endpackage

// File: rtl/reorder_buffer_rob_entry_store.sv
// rob_entry_store
// Entry arrays of the reorder buffer. One write port for allocation, one for
// CDB writeback, a retire port that frees the head, and a flush that frees all.
// Reads: asynchronous head read plus two operand probes with CDB bypass.
// Ports: clk, rst; flush; alloc_* write; cdb_* write; retire_we/head_idx;
//        head_* read; q1_id/q2_id probes -> q*_ready/q*_value.
module rob_entry_store
  import reorder_buffer_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      alloc_we,
  input  rob_idx_t  alloc_idx,
  input  rob_type_t alloc_type,
  input  reg_pos_t  alloc_rd,
  input  data_t     alloc_pc,
  input  logic      alloc_pred_taken,
  input  logic      cdb_valid,
  input  rob_id_t   cdb_rob_id,
  input  data_t     cdb_value,
  input  logic      cdb_taken,
  input  data_t     cdb_target,
  input  logic      retire_we,
  input  rob_idx_t  head_idx,
  output logic      head_ready,
  output rob_type_t head_type,
  output reg_pos_t  head_rd,
  output data_t     head_value,
  output data_t     head_pc,
  output logic      head_pred_taken,
  output logic      head_taken,
  output data_t     head_target,
  input  rob_id_t   q1_id,
  input  rob_id_t   q2_id,
  output logic      q1_ready,
  output data_t     q1_value,
  output logic      q2_ready,
  output data_t     q2_value
);

  logic [ROB_SIZE-1:0] busy;
  logic [ROB_SIZE-1:0] ready;
  rob_type_t           type_q   [ROB_SIZE];
  reg_pos_t            rd_q     [ROB_SIZE];
  data_t               pc_q     [ROB_SIZE];
  logic                pred_q   [ROB_SIZE];
  data_t               value_q  [ROB_SIZE];
  logic                taken_q  [ROB_SIZE];
  data_t               target_q [ROB_SIZE];

  rob_idx_t cdb_idx;
  logic     cdb_hit;

  assign cdb_idx = tag_to_idx(cdb_rob_id);
  assign cdb_hit = cdb_valid && tag_in_range(cdb_rob_id) && busy[cdb_idx];

  // Retire is applied after the CDB write so a repeated broadcast of the
  // retiring tag cannot leave a stale ready bit behind.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy  <= '0;
      ready <= '0;
    end else begin
      if (cdb_hit) ready[cdb_idx] <= 1'b1;
      if (retire_we) begin
        busy[head_idx]  <= 1'b0;
        ready[head_idx] <= 1'b0;
      end
      if (alloc_we) begin
        busy[alloc_idx]  <= 1'b1;
        ready[alloc_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_we) begin
      type_q[alloc_idx] <= alloc_type;
      rd_q[alloc_idx]   <= alloc_rd;
      pc_q[alloc_idx]   <= alloc_pc;
      pred_q[alloc_idx] <= alloc_pred_taken;
    end
    if (cdb_hit) begin
      value_q[cdb_idx]  <= cdb_value;
      taken_q[cdb_idx]  <= cdb_taken;
      target_q[cdb_idx] <= cdb_target;
    end
  end

  assign head_ready      = ready[head_idx];
  assign head_type       = type_q[head_idx];
  assign head_rd         = rd_q[head_idx];
  assign head_value      = value_q[head_idx];
  assign head_pc         = pc_q[head_idx];
  assign head_pred_taken = pred_q[head_idx];
  assign head_taken      = taken_q[head_idx];
  assign head_target     = target_q[head_idx];

  always_comb begin
    q1_ready = 1'b0;
    q1_value = '0;
    if (q1_id != INVALID_ROB) begin
      if (cdb_valid && cdb_rob_id == q1_id) begin
        q1_ready = 1'b1;
        q1_value = cdb_value;
      end else if (tag_in_range(q1_id) && ready[tag_to_idx(q1_id)]) begin
        q1_ready = 1'b1;
        q1_value = value_q[tag_to_idx(q1_id)];
      end
    end
  end

  always_comb begin
    q2_ready = 1'b0;
    q2_value = '0;
    if (q2_id != INVALID_ROB) begin
      if (cdb_valid && cdb_rob_id == q2_id) begin
        q2_ready = 1'b1;
        q2_value = cdb_value;
      end else if (tag_in_range(q2_id) && ready[tag_to_idx(q2_id)]) begin
        q2_ready = 1'b1;
        q2_value = value_q[tag_to_idx(q2_id)];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer
// Circular in-order reorder buffer. Allocates tags at dispatch, captures CDB
// results, retires one entry per cycle in program order and flushes on a
// branch mispredict detected at commit.
// Ports: clk, rst (sync, active-high); alloc_* dispatch + alloc_rob_id/full;
//        q1/q2 operand probes; cdb_* writeback; commit_* and store_commit_sign
//        to the register file / LSB; rollback_sign/rollback_pc redirect.
// Option: define ROB_MISPREDICT_CNT_EN to add the saturating mispredict_count
//         output; without it the port and counter are absent.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        alloc_valid,
  input  logic [1:0]  alloc_type,
  input  logic [4:0]  alloc_rd,
  input  logic [31:0] alloc_pc,
  input  logic        alloc_pred_taken,
  output logic [4:0]  alloc_rob_id,
  output logic        full,
  input  logic [4:0]  q1_id,
  input  logic [4:0]  q2_id,
  output logic        q1_ready,
  output logic        q2_ready,
  output logic [31:0] q1_value,
  output logic [31:0] q2_value,
  input  logic        cdb_valid,
  input  logic [4:0]  cdb_rob_id,
  input  logic [31:0] cdb_value,
  input  logic        cdb_taken,
  input  logic [31:0] cdb_target,
  output logic        commit_sign,
  output logic [4:0]  commit_rd,
  output logic [31:0] commit_value,
  output logic [4:0]  commit_rob_id,
  output logic        store_commit_sign,
  output logic        rollback_sign,
`ifdef ROB_MISPREDICT_CNT_EN
  output logic [31:0] mispredict_count,
`endif
  output logic [31:0] rollback_pc
);

  rob_idx_t  head, tail;
  logic [ROB_IDX_W:0] count;

  logic      head_ready, head_pred_taken, head_taken;
  rob_type_t head_type;
  reg_pos_t  head_rd;
  data_t     head_value, head_pc, head_target;

  logic commit_fire, mispredict, retire, alloc_fire;

  assign full         = (count == (ROB_IDX_W+1)'(ROB_SIZE));
  assign alloc_rob_id = idx_to_tag(tail);

  assign commit_fire = (count != '0) && head_ready;
  assign mispredict  = commit_fire && (head_type == ROB_TYPE_BRANCH) &&
                       (head_taken != head_pred_taken);
  assign retire      = commit_fire && !mispredict;
  assign alloc_fire  = alloc_valid && !full && !mispredict;

  rob_entry_store u_store (
    .clk             (clk),
    .rst             (rst),
    .flush           (mispredict),
    .alloc_we        (alloc_fire),
    .alloc_idx       (tail),
    .alloc_type      (rob_type_t'(alloc_type)),
    .alloc_rd        (alloc_rd),
    .alloc_pc        (alloc_pc),
    .alloc_pred_taken(alloc_pred_taken),
    .cdb_valid       (cdb_valid),
    .cdb_rob_id      (cdb_rob_id),
    .cdb_value       (cdb_value),
    .cdb_taken       (cdb_taken),
    .cdb_target      (cdb_target),
    .retire_we       (retire),
    .head_idx        (head),
    .head_ready      (head_ready),
    .head_type       (head_type),
    .head_rd         (head_rd),
    .head_value      (head_value),
    .head_pc         (head_pc),
    .head_pred_taken (head_pred_taken),
    .head_taken      (head_taken),
    .head_target     (head_target),
    .q1_id           (q1_id),
    .q2_id           (q2_id),
    .q1_ready        (q1_ready),
    .q1_value        (q1_value),
    .q2_ready        (q2_ready),
    .q2_value        (q2_value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      commit_sign       <= 1'b0;
      commit_rd         <= '0;
      commit_value      <= '0;
      commit_rob_id     <= INVALID_ROB;
      store_commit_sign <= 1'b0;
      rollback_sign     <= 1'b0;
      rollback_pc       <= '0;
    end else begin
      commit_sign       <= 1'b0;
      store_commit_sign <= 1'b0;
      rollback_sign     <= 1'b0;
      if (mispredict) begin
        // The mispredicting branch and everything younger are discarded.
        head          <= '0;
        tail          <= '0;
        count         <= '0;
        rollback_sign <= 1'b1;
        rollback_pc   <= head_taken ? head_target : head_pc + 32'd4;
      end else begin
        if (alloc_fire) tail <= tail + rob_idx_t'(1);
        if (retire)     head <= head + rob_idx_t'(1);
        if (alloc_fire && !retire)      count <= count + 1'b1;
        else if (!alloc_fire && retire) count <= count - 1'b1;
        if (retire) begin
          commit_rd     <= head_rd;
          commit_value  <= head_value;
          commit_rob_id <= idx_to_tag(head);
          case (head_type)
            ROB_TYPE_STORE:  store_commit_sign <= 1'b1;
            ROB_TYPE_BRANCH: commit_sign       <= (head_rd != ZERO_REG);
            default:         commit_sign       <= 1'b1;
          endcase
        end
      end
    end
  end

`ifdef ROB_MISPREDICT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_count <= '0;
    end else if (mispredict && (mispredict_count != 32'hFFFF_FFFF)) begin
      mispredict_count <= mispredict_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer for the Tomasulo core.
- Allocates a tag per dispatched instruction and captures results from the CDB.
- Retires one instruction per cycle in program order. Commits feed the register file's commit/rollback inputs; store commits go to the LSB.
- Detects branch mispredicts at commit and broadcasts a flush plus the redirect PC.

Parameters:
- ROB_SIZE, 16, number of entries (power of 2).
- ROB_ID_W, 5, tag width. Tag 0 = INVALID_ROB; entry index i carries tag i+1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- alloc_valid  in  1  dispatch requests an entry this cycle.
- alloc_type  in  2  0=reg-write, 1=store, 2=branch.
- alloc_rd  in  5  destination register; 0 = none.
- alloc_pc  in  32  instruction PC.
- alloc_pred_taken  in  1  predictor decision (branch only).
- alloc_rob_id  out  ROB_ID_W  tag the current alloc receives (combinational, tail+1).
- full  out  1  count == ROB_SIZE.
- q1_id, q2_id  in  ROB_ID_W  operand tags to probe.
- q1_ready, q2_ready  out  1  probed entry has its value.
- q1_value, q2_value  out  32  probed value.
- cdb_valid  in  1  CDB broadcast.
- cdb_rob_id  in  ROB_ID_W  producing tag.
- cdb_value  in  32  result.
- cdb_taken  in  1  actual branch outcome.
- cdb_target  in  32  taken-branch target.
- commit_sign  out  1  one-cycle commit pulse to the register file.
- commit_rd  out  5  committed destination register.
- commit_value  out  32  committed value.
- commit_rob_id  out  ROB_ID_W  committed tag.
- store_commit_sign  out  1  head store released to the LSB.
- rollback_sign  out  1  one-cycle flush pulse.
- rollback_pc  out  32  redirect PC.

Behaviour:
- Reset (rst, synchronous, active-high; clock clk):
  - head=tail=count=0; all busy/ready bits cleared.
  - All registered outputs 0; commit_rob_id=INVALID_ROB.
- Allocate:
  - Occurs when alloc_valid && !full.
  - Entry[tail] gets busy=1, ready=0 and the alloc fields; tail wraps modulo ROB_SIZE.
  - full blocks allocation even when a commit happens in the same cycle.
- Writeback:
  - On cdb_valid, if entry[cdb_rob_id-1] is busy: store value/taken/target and set ready.
  - Tag 0 or a non-busy entry: ignore.
- Probe:
  - qN_ready/value are combinational.
  - If cdb_valid and cdb_rob_id==qN_id, return cdb_value with ready=1 (bypass).
  - qN_id==0 gives ready=0, value=0.
- Commit:
  - Condition: count>0 && entry[head].ready && no rollback this cycle.
  - Outputs are registered: they pulse the cycle after the edge that retires the entry.
  - A CDB write to the head in cycle N lets it retire at the edge ending cycle N+1.
  - Reg-write: commit_sign=1 with rd/value/id. rd=0 still pulses with commit_rd=0.
  - Store: store_commit_sign=1, commit_sign=0.
  - Branch: commit_sign=1 only if rd!=0 (JAL-style link).
- Mispredict:
  - Condition: the committing branch has taken != pred_taken.
  - At that edge, clear all entries, head=tail=count=0, and register rollback_sign=1.
  - rollback_pc = cdb_target if taken, else pc+4.
  - Any allocation in the same cycle is discarded.
- Counting:
  - Alloc and commit in the same cycle leave count unchanged.
  - Pointers wrap from ROB_SIZE-1 to 0.

Optional Feature:
- Macro ROB_MISPREDICT_CNT_EN.
- Defined: adds output mispredict_count [31:0]. It increments on each rollback, resets to 0, and saturates at 0xFFFFFFFF.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Decomposition:
- defines.v holds:
  - ROB_ID_TYPE, INVALID_ROB, ROB_SIZE, DATA_TYPE, REG_POS_TYPE, ZERO_REG.
  - ROB_TYPE_REG/STORE/BRANCH encodings.
- Sub-module rob_entry_store:
  - Holds the entry arrays with one write port each for alloc and CDB.
  - Provides an async read of head plus the two probes.
- Pointer, commit and rollback control stays in reorder_buffer.

Test Plan:
- Alloc 3 reg-writes (rd=1,2,3) while tags 1,2,3 are issued; CDB tags 3,1,2 with values 0x33,0x11,0x22 → commits in order 1,2,3 on consecutive cycles with matching rd/value.
- Fill 16 entries → full=1 and a 17th alloc is ignored. Write back and commit tag 1 → full=0 and the next alloc gets tag 1 (wrap).
- Branch pc=0x100, pred_taken=0, CDB taken=1, target=0x200 → rollback_sign pulse, rollback_pc=0x200, count=0. An alloc in the same cycle is dropped.
- Correctly predicted branch pc=0x40 (pred 1, actual 1), rd=0 → no commit_sign, no rollback, head advances.
- Probe q1_id=5 in the same cycle as CDB tag 5 value 0xAB → q1_ready=1, q1_value=0xAB.
- Store at head, ready → store_commit_sign=1, commit_sign=0.
- rst asserted mid-fill → all outputs 0 and the next alloc_rob_id=1.
